mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the inst/data requester ports and the shared downstream port of mem_arbiter.
// slave is the arbiter's view; master is the surrounding core/memory environment.
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [2:0]  inst_size;
    logic        inst_cache;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [2:0]  data_size;
    logic [31:0] data_wdata;
    logic        data_cache;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        m_req;
    logic        m_wr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [31:0] m_wdata;
    logic        m_cache;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    modport slave (
        input  inst_req, inst_addr, inst_size, inst_cache,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_size, data_wdata, data_cache,
        output data_addr_ok, data_data_ok, data_rdata,
        output m_req, m_wr, m_wstrb, m_addr, m_size, m_wdata, m_cache,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport master (
        output inst_req, inst_addr, inst_size, inst_cache,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_size, data_wdata, data_cache,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  m_req, m_wr, m_wstrb, m_addr, m_size, m_wdata, m_cache,
        output m_addr_ok, m_data_ok, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one in-order downstream port between inst and data requesters (data has priority).
// Define MEM_ARB_STARVE_GUARD_EN to force an inst grant after STARVE_MAX consecutive data grants.
module mem_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave io_bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("mem_arbiter: DEPTH must be a power of two in 2..16");
    end
    if (STARVE_MAX < 1) begin : g_starve_chk
        $error("mem_arbiter: STARVE_MAX must be at least 1");
    end

    logic            w_force_inst;
    logic            w_grant_data;
    logic            w_grant_inst;
    logic            w_push;
    logic            w_pop;
    logic            w_head_id;

    // ID FIFO: 0 = inst, 1 = data; order of acceptance equals order of responses.
    logic            r_id_fifo [DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    assign w_grant_data = io_bus.data_req && !w_force_inst;
    assign w_grant_inst = !w_grant_data && io_bus.inst_req;

    // Registered count only: a pop at full never frees a slot in the same cycle.
    assign io_bus.m_req   = !reset && (w_grant_data || w_grant_inst) && (r_count < CntFull);
    assign io_bus.m_wr    = w_grant_data && io_bus.data_wr;
    assign io_bus.m_wstrb = w_grant_data ? io_bus.data_wstrb : 4'd0;
    assign io_bus.m_wdata = w_grant_data ? io_bus.data_wdata : 32'd0;
    assign io_bus.m_addr  = w_grant_data ? io_bus.data_addr  : io_bus.inst_addr;
    assign io_bus.m_size  = w_grant_data ? io_bus.data_size  : io_bus.inst_size;
    assign io_bus.m_cache = w_grant_data ? io_bus.data_cache : io_bus.inst_cache;

    assign w_push              = io_bus.m_req && io_bus.m_addr_ok;
    assign io_bus.inst_addr_ok = w_push && w_grant_inst;
    assign io_bus.data_addr_ok = w_push && w_grant_data;

    // Responses with nothing outstanding are dropped.
    assign w_pop               = !reset && io_bus.m_data_ok && (r_count != '0);
    assign w_head_id           = r_id_fifo[r_rd_ptr];
    assign io_bus.inst_data_ok = w_pop && !w_head_id;
    assign io_bus.data_data_ok = w_pop && w_head_id;
    assign io_bus.inst_rdata   = io_bus.m_rdata;
    assign io_bus.data_rdata   = io_bus.m_rdata;

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_id_fifo[r_wr_ptr] <= w_grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam logic [StarveW-1:0] StarveLim = StarveW'(STARVE_MAX);

    logic [StarveW-1:0] r_starve_cnt;

    // Holds at the limit until inst is accepted or withdraws its request.
    assign w_force_inst = io_bus.inst_req && (r_starve_cnt == StarveLim);

    always_ff @(posedge clk) begin
        if (reset || !io_bus.inst_req || io_bus.inst_addr_ok) begin
            r_starve_cnt <= '0;
        end else if (io_bus.data_addr_ok && (r_starve_cnt != StarveLim)) begin
            r_starve_cnt <= r_starve_cnt + StarveW'(1);
        end
    end
`else
    assign w_force_inst = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural ID scoreboard checked every cycle.
// Compile with +define+MEM_ARB_STARVE_GUARD_EN to check the starvation-guard build.
module tb_mem_arbiter;
    localparam int unsigned Depth     = 4;
    localparam int unsigned StarveMax = 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GuardEn = 1'b1;
`else
    localparam bit GuardEn = 1'b0;
`endif

    logic clk;
    logic reset;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .DEPTH      (Depth),
        .STARVE_MAX (StarveMax)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_errors;
    int cyc;

    // Expected requester IDs of accepted-but-unanswered transactions (0 inst, 1 data).
    bit exp_q[$];
    int starve;

    int phase_acc;
    int first_inst;
    int n_inst_acc;

    logic [31:0] s_iaddr, s_daddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [2:0]  s_isize, s_dsize;
    logic        s_wr, s_icache, s_dcache;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit ir, input bit dr, input bit aok,
                         input bit dok, input logic [31:0] rd);
        bit force_i, gd, gi, mreq, acc, pop, head;
        @(negedge clk);
        cyc++;
        s_iaddr  = 32'h1000_0000 | 32'(cyc);
        s_daddr  = 32'h2000_0000 | 32'(cyc);
        s_wdata  = $urandom;
        s_wstrb  = 4'($urandom);
        s_wr     = 1'($urandom);
        s_isize  = 3'd2;
        s_dsize  = 3'($urandom_range(0, 2));
        s_icache = 1'($urandom);
        s_dcache = 1'($urandom);

        reset           = rst;
        bus.inst_req    = ir;
        bus.inst_addr   = s_iaddr;
        bus.inst_size   = s_isize;
        bus.inst_cache  = s_icache;
        bus.data_req    = dr;
        bus.data_wr     = s_wr;
        bus.data_wstrb  = s_wstrb;
        bus.data_addr   = s_daddr;
        bus.data_size   = s_dsize;
        bus.data_wdata  = s_wdata;
        bus.data_cache  = s_dcache;
        bus.m_addr_ok   = aok;
        bus.m_data_ok   = dok;
        bus.m_rdata     = rd;
        #1;

        force_i = GuardEn && ir && (starve == StarveMax);
        gd      = dr && !force_i;
        gi      = !gd && ir;
        mreq    = !rst && (gd || gi) && (exp_q.size() < Depth);
        acc     = mreq && aok;
        pop     = !rst && dok && (exp_q.size() != 0);
        head    = pop ? exp_q[0] : 1'b0;

        check_eq("m_req", 32'(bus.m_req), 32'(mreq));
        check_eq("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(acc && gi));
        check_eq("data_addr_ok", 32'(bus.data_addr_ok), 32'(acc && gd));
        check_eq("inst_data_ok", 32'(bus.inst_data_ok), 32'(pop && !head));
        check_eq("data_data_ok", 32'(bus.data_data_ok), 32'(pop && head));
        if (mreq) begin
            check_eq("m_addr", bus.m_addr, gd ? s_daddr : s_iaddr);
            check_eq("m_wdata", bus.m_wdata, gd ? s_wdata : 32'd0);
            check_eq("m_ctrl", 32'({bus.m_wr, bus.m_wstrb, bus.m_size, bus.m_cache}),
                     gd ? 32'({s_wr, s_wstrb, s_dsize, s_dcache})
                        : 32'({1'b0, 4'd0, s_isize, s_icache}));
        end
        if (pop) begin
            check_eq("inst_rdata", bus.inst_rdata, rd);
            check_eq("data_rdata", bus.data_rdata, rd);
        end

        if (bus.inst_addr_ok || bus.data_addr_ok) phase_acc++;
        if (bus.inst_addr_ok) begin
            n_inst_acc++;
            if (first_inst == 0) first_inst = phase_acc;
        end

        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            starve = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(gd);
            if (!ir || (acc && gi)) starve = 0;
            else if (acc && gd && starve < StarveMax) starve++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        starve   = 0;
        reset    = 1'b1;
        bus.inst_req  = 1'b0;
        bus.data_req  = 1'b0;
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b0;
        bus.m_rdata   = 32'd0;

        // Reset: everything quiet even with live requests and responses.
        cycle(1, 0, 0, 0, 0, 32'd0);
        cycle(1, 1, 1, 1, 1, 32'hdead_beef);

        // Both request, data wins; response routed to data.
        cycle(0, 1, 1, 1, 0, 32'd0);
        cycle(0, 0, 0, 0, 1, 32'h1234_5678);

        // Response with empty FIFO is ignored.
        cycle(0, 0, 0, 0, 1, 32'hcafe_0001);

        // In-order routing: inst, data, inst.
        cycle(0, 1, 0, 1, 0, 32'd0);
        cycle(0, 0, 1, 1, 0, 32'd0);
        cycle(0, 1, 0, 1, 0, 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, $urandom);

        // Fill to DEPTH, then full behaviour with and without a same-cycle pop.
        for (int i = 0; i < 4; i++) cycle(0, i[0], !i[0], 1, 0, 32'd0);
        cycle(0, 1, 0, 1, 0, 32'd0);
        cycle(0, 1, 0, 1, 1, 32'haaaa_0001);
        cycle(0, 1, 0, 1, 0, 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, $urandom);

        // Simultaneous push and pop below full.
        cycle(0, 0, 1, 1, 0, 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 1, i[0], 1, 1, $urandom);
        cycle(0, 0, 0, 0, 1, 32'hbbbb_0002);

        // Reset mid-transaction discards outstanding IDs.
        cycle(0, 1, 0, 1, 0, 32'd0);
        cycle(0, 0, 1, 1, 0, 32'd0);
        cycle(1, 0, 0, 0, 0, 32'd0);
        cycle(0, 0, 0, 0, 1, 32'hcccc_0003);
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 0, 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, $urandom);

        // Starvation: both held high with responses every cycle.
        cycle(1, 0, 0, 0, 0, 32'd0);
        phase_acc  = 0;
        first_inst = 0;
        n_inst_acc = 0;
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 1, 1, $urandom);
        check_eq("starve_accepts", 32'(phase_acc), 32'd20);
`ifdef MEM_ARB_STARVE_GUARD_EN
        check_eq("starve_first_inst", 32'(first_inst), 32'd9);
        check_eq("starve_inst_count", 32'(n_inst_acc), 32'd2);
`else
        check_eq("starve_inst_count", 32'(n_inst_acc), 32'd0);
`endif
        cycle(0, 0, 0, 0, 1, $urandom);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 120; i++) begin
            cycle(0, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), $urandom);
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, $urandom);
        check_eq("drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
